// File: rtl/rsa_ctrl_pkg.sv
// Shared types and helpers for the RSA enable/clear sequencer.
package rsa_ctrl_pkg;

    typedef enum logic [2:0] {
        RESET       = 3'd0,
        IDLE        = 3'd1,
        EN          = 3'd2,
        RST_RELEASE = 3'd3,
        WAIT_EOC    = 3'd4,
        EOC         = 3'd5,
        TIMEOUT     = 3'd6
    } rsa_seq_state_t;

    localparam int STOP_ALL = 0;
    localparam int STOP_ANY = 1;

    // Output pattern {en_rsa, clear_rsa, eoc, busy} held while in a state.
    // Anything not listed (RESET, IDLE, illegal codes) drives all zeros.
    function automatic logic [3:0] state_outputs(input rsa_seq_state_t s);
        logic [3:0] o;
        o = 4'b0000;
        case (s)
            EN:          o = 4'b1001;
            RST_RELEASE: o = 4'b1101;
            WAIT_EOC:    o = 4'b1101;
            EOC:         o = 4'b1111;
            TIMEOUT:     o = 4'b0001;
            default:     o = 4'b0000;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/rsa_src_arbiter.sv
// Combines the maskable start/stop request sources into one start request,
// one stop condition and the index of the lowest requesting start source.
module rsa_src_arbiter
    import rsa_ctrl_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int STOP_MODE = STOP_ALL,
    parameter int AS_W      = $clog2(NUM_SRC) + 1
) (
    input  logic [NUM_SRC-1:0] start_i,
    input  logic [NUM_SRC-1:0] stop_i,
    input  logic [NUM_SRC-1:0] src_mask,
    output logic               start_any,
    output logic               stop_cond,
    output logic [AS_W-1:0]    start_idx
);

    logic [NUM_SRC-1:0] start_req;

    assign start_req = start_i & src_mask;
    assign start_any = |start_req;

    // An empty mask must never produce a stop, even in the all-sources mode.
    generate
        if (STOP_MODE == STOP_ANY) begin : g_stop_any
            assign stop_cond = |(stop_i & src_mask);
        end else begin : g_stop_all
            assign stop_cond = (|src_mask) && (&(stop_i | ~src_mask));
        end
    endgenerate

    // Priority encoder: scanning downwards lets the lowest set index win.
    always_comb begin
        start_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (start_req[i]) start_idx = AS_W'(i);
        end
    end

endmodule

// File: rtl/rsa_ctrl_seq.sv
// RSA enable/clear sequencer: arbitrates start/stop sources, steps en_rsa and
// clear_rsa around one rsa_unit encryption, with watchdog, auto-rerun,
// saturating run counter and sticky timeout flag.
module rsa_ctrl_seq
    import rsa_ctrl_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int STOP_MODE = STOP_ALL,
    parameter int TO_W      = 16,
    parameter int CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [NUM_SRC-1:0]       start_i,
    input  logic [NUM_SRC-1:0]       stop_i,
    input  logic [NUM_SRC-1:0]       src_mask,
    input  logic                     auto_rerun,
    input  logic [TO_W-1:0]          timeout_cycles,
    input  logic                     clr_err,
    input  logic                     eoc_rsa_unit,
    output logic                     en_rsa,
    output logic                     clear_rsa,
    output logic                     eoc,
    output logic                     busy,
    output logic                     timeout_err,
    output logic [$clog2(NUM_SRC):0] active_src,
    output logic [CNT_W-1:0]         run_count
);

    localparam int AS_W = $clog2(NUM_SRC) + 1;

    rsa_seq_state_t  state;
    rsa_seq_state_t  state_nxt;
    logic [TO_W-1:0] wdog;
    logic            eoc_q;
    logic            start_any;
    logic            stop_cond;
    logic [AS_W-1:0] start_idx;

    rsa_src_arbiter #(
        .NUM_SRC  (NUM_SRC),
        .STOP_MODE(STOP_MODE),
        .AS_W     (AS_W)
    ) u_arb (
        .start_i  (start_i),
        .stop_i   (stop_i),
        .src_mask (src_mask),
        .start_any(start_any),
        .stop_cond(stop_cond),
        .start_idx(start_idx)
    );

    // Next-state selection; in WAIT_EOC a stop beats eoc, which beats the watchdog.
    always_comb begin
        state_nxt = state;
        case (state)
            RESET:       state_nxt = IDLE;
            IDLE:        if (start_any) state_nxt = EN;
            EN:          state_nxt = stop_cond ? IDLE : RST_RELEASE;
            RST_RELEASE: state_nxt = stop_cond ? IDLE : WAIT_EOC;
            WAIT_EOC: begin
                if (stop_cond)
                    state_nxt = IDLE;
                else if (eoc_rsa_unit)
                    state_nxt = EOC;
                else if ((timeout_cycles != '0) && (wdog >= timeout_cycles))
                    state_nxt = TIMEOUT;
            end
            EOC:         state_nxt = (auto_rerun && !stop_cond) ? EN : IDLE;
            TIMEOUT:     state_nxt = IDLE;
            default:     state_nxt = RESET;
        endcase
    end

    // FSM register with outputs registered from the state being entered; ena=0 freezes it all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RESET;
            en_rsa     <= 1'b0;
            clear_rsa  <= 1'b0;
            eoc_q      <= 1'b0;
            busy       <= 1'b0;
            wdog       <= '0;
            active_src <= '0;
        end else if (ena) begin
            state <= state_nxt;
            {en_rsa, clear_rsa, eoc_q, busy} <= state_outputs(state_nxt);
            if (state == IDLE && state_nxt == EN) active_src <= start_idx;
            case (state)
                EN:          wdog <= '0;
                RST_RELEASE: if (wdog != '1) wdog <= wdog + 1'b1;
                WAIT_EOC:    if (state_nxt == WAIT_EOC && wdog != '1) wdog <= wdog + 1'b1;
                default:     ;
            endcase
        end
    end

    // Run counter and sticky timeout flag; a timeout set beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_count   <= '0;
            timeout_err <= 1'b0;
        end else if (ena) begin
            if (state == TIMEOUT)
                timeout_err <= 1'b1;
            else if (clr_err)
                timeout_err <= 1'b0;

            if (clr_err)
                run_count <= (state == EOC) ? CNT_W'(1) : '0;
            else if (state == EOC && run_count != '1)
                run_count <= run_count + 1'b1;
        end
    end

    // The end-of-conversion pulse is suppressed while the sequencer is frozen.
    assign eoc = eoc_q & ena;

endmodule

// File: tb/tb_rsa_ctrl_seq.sv
// Directed bench for rsa_ctrl_seq: one instance per stop policy, shared stimulus.
module tb_rsa_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [1:0]  start_i;
    logic [1:0]  stop_i;
    logic [1:0]  src_mask;
    logic        auto_rerun;
    logic [15:0] timeout_cycles;
    logic        clr_err;
    logic        eoc_rsa_unit;

    logic        en_rsa, clear_rsa, eoc, busy, timeout_err;
    logic [1:0]  active_src;
    logic [7:0]  run_count;

    logic        a_en_rsa, a_clear_rsa, a_eoc, a_busy, a_timeout_err;
    logic [1:0]  a_active_src;
    logic [7:0]  a_run_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rsa_ctrl_seq #(.NUM_SRC(2), .STOP_MODE(0), .TO_W(16), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .start_i(start_i), .stop_i(stop_i),
        .src_mask(src_mask), .auto_rerun(auto_rerun), .timeout_cycles(timeout_cycles),
        .clr_err(clr_err), .eoc_rsa_unit(eoc_rsa_unit), .en_rsa(en_rsa),
        .clear_rsa(clear_rsa), .eoc(eoc), .busy(busy), .timeout_err(timeout_err),
        .active_src(active_src), .run_count(run_count)
    );

    rsa_ctrl_seq #(.NUM_SRC(2), .STOP_MODE(1), .TO_W(16), .CNT_W(8)) u_any (
        .clk(clk), .rst(rst), .ena(ena), .start_i(start_i), .stop_i(stop_i),
        .src_mask(src_mask), .auto_rerun(auto_rerun), .timeout_cycles(timeout_cycles),
        .clr_err(clr_err), .eoc_rsa_unit(eoc_rsa_unit), .en_rsa(a_en_rsa),
        .clear_rsa(a_clear_rsa), .eoc(a_eoc), .busy(a_busy), .timeout_err(a_timeout_err),
        .active_src(a_active_src), .run_count(a_run_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b1; ena = 1'b1; start_i = 2'b00; stop_i = 2'b00; src_mask = 2'b11;
        auto_rerun = 1'b0; timeout_cycles = 16'd0; clr_err = 1'b0; eoc_rsa_unit = 1'b0;
        repeat (2) tick();

        // reset state
        check("rst_en", en_rsa, 0);
        check("rst_clear", clear_rsa, 0);
        check("rst_eoc", eoc, 0);
        check("rst_busy", busy, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_cnt", run_count, 0);
        check("rst_src", active_src, 0);
        check("rst_any_outs", {a_en_rsa, a_clear_rsa, a_eoc, a_busy, a_timeout_err}, 0);
        check("rst_any_regs", {a_active_src, a_run_count}, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // basic run launched by source 1
        start_i = 2'b10;
        tick();
        check("t1_en", en_rsa, 1);
        check("t1_clear_low", clear_rsa, 0);
        check("t1_busy", busy, 1);
        check("t1_src", active_src, 1);
        start_i = 2'b00;
        tick();
        check("t1_clear_high", clear_rsa, 1);
        tick();
        repeat (7) tick();
        check("t1_wait_eoc", eoc, 0);
        check("t1_wait_busy", busy, 1);
        eoc_rsa_unit = 1'b1;
        tick();
        check("t1_eoc", eoc, 1);
        check("t1_cnt_pre", run_count, 0);
        eoc_rsa_unit = 1'b0;
        tick();
        check("t1_eoc_end", eoc, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_en", en_rsa, 0);
        check("t1_cnt", run_count, 1);
        check("t1_any_cnt", a_run_count, 1);

        // stop policies: all-sources vs any-source
        start_i = 2'b01;
        tick();
        check("t2_src", active_src, 0);
        start_i = 2'b00;
        tick();
        tick();
        stop_i = 2'b01;
        tick();
        check("t2_all_partial_stay", en_rsa, 1);
        check("t2_any_stop_en", a_en_rsa, 0);
        check("t2_any_stop_busy", a_busy, 0);
        stop_i = 2'b11;
        tick();
        check("t2_all_stop_en", en_rsa, 0);
        check("t2_all_stop_busy", busy, 0);
        stop_i = 2'b00;

        // watchdog abort with limit 5
        timeout_cycles = 16'd5;
        start_i = 2'b11;
        tick();
        check("t3_src_lowest", active_src, 0);
        start_i = 2'b00;
        repeat (6) tick();
        check("t3_pre_timeout_en", en_rsa, 1);
        tick();
        check("t3_timeout_en", en_rsa, 0);
        check("t3_timeout_busy", busy, 1);
        check("t3_timeout_terr_pre", timeout_err, 0);
        tick();
        check("t3_terr", timeout_err, 1);
        check("t3_idle_busy", busy, 0);
        check("t3_any_terr", a_timeout_err, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t3_terr_clr", timeout_err, 0);
        check("t3_cnt_clr", run_count, 0);

        // watchdog disabled
        timeout_cycles = 16'd0;
        start_i = 2'b01;
        tick();
        start_i = 2'b00;
        repeat (1000) tick();
        check("t3_nowd_en", en_rsa, 1);
        check("t3_nowd_terr", timeout_err, 0);
        stop_i = 2'b11;
        tick();
        check("t3_nowd_stop", busy, 0);
        stop_i = 2'b00;

        // ena freeze in WAIT_EOC, masked lowest-index capture
        src_mask = 2'b10;
        start_i = 2'b11;
        tick();
        check("t5_src_masked", active_src, 1);
        start_i = 2'b00;
        tick();
        tick();
        ena = 1'b0;
        eoc_rsa_unit = 1'b1;
        repeat (3) tick();
        check("t5_frozen_eoc", eoc, 0);
        check("t5_frozen_en", en_rsa, 1);
        check("t5_frozen_cnt", run_count, 0);
        ena = 1'b1;
        tick();
        check("t5_eoc", eoc, 1);
        eoc_rsa_unit = 1'b0;
        tick();
        check("t5_cnt", run_count, 1);
        check("t5_idle", busy, 0);
        src_mask = 2'b11;

        // auto-rerun cadence and counter saturation
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        auto_rerun = 1'b1;
        eoc_rsa_unit = 1'b1;
        start_i = 2'b01;
        tick();
        start_i = 2'b00;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("t4_eoc_phase", eoc, ((k % 4) == 3) ? 1 : 0);
            check("t4_clear_phase", clear_rsa, ((k % 4) != 0) ? 1 : 0);
        end
        check("t4_cnt_3", run_count, 3);
        check("t4_src_hold", active_src, 0);
        repeat (1100) tick();
        check("t4_cnt_sat", run_count, 255);
        for (int i = 0; i < 8 && !eoc; i++) tick();
        check("t4_eoc_found", eoc, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t4_clr_with_eoc", run_count, 1);
        auto_rerun = 1'b0;
        eoc_rsa_unit = 1'b0;
        stop_i = 2'b11;
        tick();
        check("t4_stopped", busy, 0);
        stop_i = 2'b00;

        // async reset mid-run, then empty mask
        start_i = 2'b01;
        tick();
        start_i = 2'b00;
        tick();
        tick();
        check("t6_running", clear_rsa, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_en", en_rsa, 0);
        check("t6_rst_clear", clear_rsa, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_cnt", run_count, 0);
        tick();
        rst = 1'b0;
        tick();
        src_mask = 2'b00;
        start_i = 2'b11;
        repeat (3) tick();
        check("t6_nomask_busy", busy, 0);
        check("t6_nomask_en", en_rsa, 0);
        start_i = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
